dpll_lock_detect: RTL and testbench

Lock detector downstream of the DPLL core. Samples the DPLL's reference input `clk_fin` and its recovered output `clk_fout`, both as data in the `wb_clk_i` domain. Compares their rising-edge counts over fixed measurement windows and qualifies lock with hysteresis through a four-state FSM. Drives a `locked` status flag, a loss-of-lock pulse and a saturating error counter for firmware and I/O.

---
 rtl/dpll_pkg.sv | 13 +
 rtl/dpll_edge_sync.sv | 32 +++
 rtl/dpll_lock_detect.sv | 227 ++++++++++++++++++++++
 tb/tb_dpll_lock_detect.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// dpll_pkg: shared types and constants for the DPLL lock detector.
package dpll_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2,
      HOLDOVER = 2'd3
   } lock_state_t;

   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/dpll_edge_sync.sv
// dpll_edge_sync: two-flop synchronizer followed by an edge-detect flop.
// Produces the synchronized level and a one-cycle rising-edge strobe.
// Both lock-detector inputs use this same block so their delays match.
module dpll_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronizer chain plus previous-level flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect: compares rising-edge counts of the DPLL reference and
// output over fixed windows and qualifies lock with hysteresis.
// Optional build macro DPLL_LOCK_PHASE_CHECK_EN additionally requires the
// XOR phase-detector duty (fin != fout cycles) to sit in the quadrature band.
module dpll_lock_detect
   import dpll_pkg::*;
#(
   parameter int WIN_LOG2       = 10,
   parameter int TOL            = 1,
   parameter int LOCK_WINDOWS   = 4,
   parameter int UNLOCK_WINDOWS = 2
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 clk_fin,
   input  logic                 clk_fout,
   input  logic                 clear_i,
   output logic                 locked,
   output logic                 lock_lost,
   output logic                 win_done,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int MAX_RUN = (LOCK_WINDOWS > UNLOCK_WINDOWS) ? LOCK_WINDOWS : UNLOCK_WINDOWS;
   localparam int RUN_W   = $clog2(MAX_RUN + 1);
   localparam logic [WIN_LOG2:0] TOL_V    = (WIN_LOG2+1)'(TOL);
   localparam logic [RUN_W:0]    LOCK_N   = (RUN_W+1)'(LOCK_WINDOWS);
   localparam logic [RUN_W:0]    UNLOCK_N = (RUN_W+1)'(UNLOCK_WINDOWS);

   logic rise_fin, rise_fout, lvl_fin, lvl_fout;

   dpll_edge_sync u_sync_fin (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .d_i     (clk_fin),
      .level_o (lvl_fin),
      .rise_o  (rise_fin)
   );

   dpll_edge_sync u_sync_fout (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .d_i     (clk_fout),
      .level_o (lvl_fout),
      .rise_o  (rise_fout)
   );

   logic [WIN_LOG2-1:0] win_cnt_q;
   logic [WIN_LOG2-1:0] fin_edges_q, fout_edges_q;
   logic [WIN_LOG2-1:0] fin_edges_d, fout_edges_d;
   logic [WIN_LOG2:0]   edge_diff;
   logic                terminal;
   logic                freq_ok;
   logic                phase_ok;
   logic                good;

   assign terminal = (win_cnt_q == '1);

   // Saturating edge counts including this cycle's strobe.
   assign fin_edges_d  = (rise_fin  && (fin_edges_q  != '1)) ? fin_edges_q  + 1'b1 : fin_edges_q;
   assign fout_edges_d = (rise_fout && (fout_edges_q != '1)) ? fout_edges_q + 1'b1 : fout_edges_q;

   // Absolute edge-count difference, one bit wider than the counters.
   always_comb begin
      edge_diff = '0;
      if (fin_edges_d >= fout_edges_d)
         edge_diff = {1'b0, fin_edges_d} - {1'b0, fout_edges_d};
      else
         edge_diff = {1'b0, fout_edges_d} - {1'b0, fin_edges_d};
   end

   assign freq_ok = (fin_edges_d != '0) && (fout_edges_d != '0) && (edge_diff <= TOL_V);

`ifdef DPLL_LOCK_PHASE_CHECK_EN
   localparam logic [WIN_LOG2:0] XOR_LO = (WIN_LOG2+1)'((2**WIN_LOG2) / 4);
   localparam logic [WIN_LOG2:0] XOR_HI = (WIN_LOG2+1)'((3 * (2**WIN_LOG2)) / 4);

   logic [WIN_LOG2:0] xor_cnt_q;
   logic [WIN_LOG2:0] xor_cnt_d;

   assign xor_cnt_d = xor_cnt_q + {{WIN_LOG2{1'b0}}, (lvl_fin ^ lvl_fout)};
   assign phase_ok  = (xor_cnt_d >= XOR_LO) && (xor_cnt_d <= XOR_HI);

   // Count cycles where the synchronized levels differ within the window.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear_i)
         xor_cnt_q <= '0;
      else if (terminal)
         xor_cnt_q <= '0;
      else
         xor_cnt_q <= xor_cnt_d;
   end
`else
   logic unused_lvl;
   assign unused_lvl = lvl_fin ^ lvl_fout;
   assign phase_ok   = 1'b1;
`endif

   assign good = freq_ok && phase_ok;

   // Window counter and edge counters; partial windows are dropped on clear.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear_i) begin
         win_cnt_q    <= '0;
         fin_edges_q  <= '0;
         fout_edges_q <= '0;
      end else begin
         win_cnt_q <= win_cnt_q + 1'b1;
         if (terminal) begin
            fin_edges_q  <= '0;
            fout_edges_q <= '0;
         end else begin
            fin_edges_q  <= fin_edges_d;
            fout_edges_q <= fout_edges_d;
         end
      end
   end

   lock_state_t          state_q, state_d;
   logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
   logic [RUN_W:0]       run_inc;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d, err_sat;
   logic                 lost_d;
   logic                 locked_d;
   logic                 locked_q, lock_lost_q, win_done_q;

   assign run_inc = {1'b0, run_cnt_q} + 1'b1;
   assign err_sat = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

   // State register plus registered status outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear_i) begin
         state_q     <= UNLOCKED;
         run_cnt_q   <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
         win_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         lock_lost_q <= lost_d;
         win_done_q  <= terminal;
      end
   end

   // Next-state logic: lock qualification with hysteresis, evaluated per window.
   always_comb begin
      state_d     = state_q;
      run_cnt_d   = run_cnt_q;
      err_count_d = err_count_q;
      lost_d      = 1'b0;
      if (terminal) begin
         case (state_q)
            UNLOCKED: begin
               if (good) begin
                  if (LOCK_WINDOWS == 1) begin
                     state_d   = LOCKED;
                     run_cnt_d = '0;
                  end else begin
                     state_d   = ACQUIRE;
                     run_cnt_d = RUN_W'(1);
                  end
               end
            end
            ACQUIRE: begin
               if (good) begin
                  if (run_inc >= LOCK_N) begin
                     state_d   = LOCKED;
                     run_cnt_d = '0;
                  end else begin
                     run_cnt_d = run_inc[RUN_W-1:0];
                  end
               end else begin
                  state_d   = UNLOCKED;
                  run_cnt_d = '0;
               end
            end
            LOCKED: begin
               if (!good) begin
                  err_count_d = err_sat;
                  if (UNLOCK_WINDOWS == 1) begin
                     state_d   = UNLOCKED;
                     run_cnt_d = '0;
                     lost_d    = 1'b1;
                  end else begin
                     state_d   = HOLDOVER;
                     run_cnt_d = RUN_W'(1);
                  end
               end
            end
            HOLDOVER: begin
               if (good) begin
                  state_d   = LOCKED;
                  run_cnt_d = '0;
               end else begin
                  err_count_d = err_sat;
                  if (run_inc >= UNLOCK_N) begin
                     state_d   = UNLOCKED;
                     run_cnt_d = '0;
                     lost_d    = 1'b1;
                  end else begin
                     run_cnt_d = run_inc[RUN_W-1:0];
                  end
               end
            end
            default: begin
               state_d   = UNLOCKED;
               run_cnt_d = '0;
            end
         endcase
      end
   end

   // Output decode: locked covers both LOCKED and HOLDOVER.
   always_comb begin
      locked_d = (state_d == LOCKED) || (state_d == HOLDOVER);
   end

   assign locked    = locked_q;
   assign lock_lost = lock_lost_q;
   assign win_done  = win_done_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_dpll_lock_detect.sv
// Directed testbench for dpll_lock_detect (WIN_LOG2=6, TOL=1, 4/2 windows).
module tb_dpll_lock_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       fin;
   logic       fout;
   logic       clr;
   logic       locked;
   logic       lock_lost;
   logic       win_done;
   logic [7:0] err_count;

   int n;
   int tests;
   int fails;
   int fin_en, fout_en, fout_per, fout_rise;
   int lost_cnt, locked_seen;

   dpll_lock_detect #(
      .WIN_LOG2       (6),
      .TOL            (1),
      .LOCK_WINDOWS   (4),
      .UNLOCK_WINDOWS (2)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .clk_fin   (fin),
      .clk_fout  (fout),
      .clear_i   (clr),
      .locked    (locked),
      .lock_lost (lock_lost),
      .win_done  (win_done),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Square wave: high for half the period starting at phase 'rise'.
   function automatic logic wave(int t, int per, int rise);
      return (((t + per * 64 - rise) % per) < (per / 2));
   endfunction

   task automatic step();
      fin  = (fin_en != 0)  ? wave(n, 16, 4) : 1'b0;
      fout = (fout_en != 0) ? wave(n, fout_per, fout_rise) : 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (lock_lost) lost_cnt++;
      if (locked) locked_seen++;
   endtask

   task automatic run(int k);
      repeat (k) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; fin = 1'b0; fout = 1'b0;
      fin_en = 1; fout_en = 1; fout_per = 16; fout_rise = 8;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0; lost_cnt = 0; locked_seen = 0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked got=%0b exp=0", locked); end
      tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL rst_lock_lost got=%0b exp=0", lock_lost); end
      tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL rst_win_done got=%0b exp=0", win_done); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rst_err got=%0d exp=0", err_count); end
      run(256);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL rst_prelock got=%0b exp=1", locked); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_mid_locked got=%0b exp=0", locked); end
      run(63);
      tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL rst_win_early got=%0b exp=0", win_done); end
      run(1);
      tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL rst_win_done_64 got=%0b exp=1", win_done); end
      run(1);
      tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL rst_win_pulse got=%0b exp=0", win_done); end
   endtask

   task automatic test_ideal_lock();
      do_reset();
      run(255);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL ideal_before got=%0b exp=0", locked); end
      run(1);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL ideal_locked got=%0b exp=1", locked); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL ideal_err got=%0d exp=0", err_count); end
      run(128);
      tests++; if (locked !== 1'b1 || lost_cnt !== 0) begin fails++; $display("FAIL ideal_stay locked=%0b lost=%0d exp=1/0", locked, lost_cnt); end
   endtask

   task automatic test_freq_error();
      do_reset();
      fout_per = 8; fout_rise = 4;
      run(512);
      tests++; if (locked_seen !== 0) begin fails++; $display("FAIL freq_locked_seen got=%0d exp=0", locked_seen); end
      tests++; if (lost_cnt !== 0) begin fails++; $display("FAIL freq_lost got=%0d exp=0", lost_cnt); end
      tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL freq_win_done got=%0b exp=1", win_done); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL freq_err got=%0d exp=0", err_count); end
   endtask

   task automatic test_holdover();
      do_reset();
      run(256);
      fout_en = 0;
      run(64);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL hold_locked got=%0b exp=1", locked); end
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL hold_err got=%0d exp=1", err_count); end
      fout_en = 1;
      run(64);
      tests++; if (locked !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL hold_recover locked=%0b err=%0d exp=1/1", locked, err_count); end
      fout_en = 0;
      run(64);
      tests++; if (locked !== 1'b1 || err_count !== 8'd2) begin fails++; $display("FAIL hold_again locked=%0b err=%0d exp=1/2", locked, err_count); end
      fout_en = 1;
      run(64);
      tests++; if (locked !== 1'b1 || lost_cnt !== 0) begin fails++; $display("FAIL hold_final locked=%0b lost=%0d exp=1/0", locked, lost_cnt); end
   endtask

   task automatic test_loss();
      do_reset();
      run(256);
      fin_en = 0;
      run(64);
      tests++; if (locked !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL loss_first locked=%0b err=%0d exp=1/1", locked, err_count); end
      run(63);
      tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL loss_early got=%0b exp=0", lock_lost); end
      run(1);
      tests++; if (lock_lost !== 1'b1) begin fails++; $display("FAIL loss_pulse got=%0b exp=1", lock_lost); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL loss_locked got=%0b exp=0", locked); end
      tests++; if (err_count !== 8'd2) begin fails++; $display("FAIL loss_err got=%0d exp=2", err_count); end
      run(1);
      tests++; if (lock_lost !== 1'b0 || lost_cnt !== 1) begin fails++; $display("FAIL loss_one_cycle pulse=%0b cnt=%0d exp=0/1", lock_lost, lost_cnt); end
      fin_en = 1;
      run(254);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL loss_relock_early got=%0b exp=0", locked); end
      run(1);
      tests++; if (locked !== 1'b1 || err_count !== 8'd2) begin fails++; $display("FAIL loss_relock locked=%0b err=%0d exp=1/2", locked, err_count); end
   endtask

   task automatic test_clear();
      do_reset();
      run(256);
      fout_en = 0;
      run(64);
      fout_en = 1;
      run(30);
      tests++; if (locked !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL clr_pre locked=%0b err=%0d exp=1/1", locked, err_count); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL clr_locked got=%0b exp=0", locked); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL clr_err got=%0d exp=0", err_count); end
      tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL clr_lost got=%0b exp=0", lock_lost); end
      run(63);
      tests++; if (win_done !== 1'b0) begin fails++; $display("FAIL clr_win_early got=%0b exp=0", win_done); end
      run(1);
      tests++; if (win_done !== 1'b1) begin fails++; $display("FAIL clr_win_done got=%0b exp=1", win_done); end
      run(191);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL clr_relock_early got=%0b exp=0", locked); end
      run(1);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clr_relock got=%0b exp=1", locked); end
      tests++; if (lost_cnt !== 0) begin fails++; $display("FAIL clr_no_lost got=%0d exp=0", lost_cnt); end
   endtask

`ifdef DPLL_LOCK_PHASE_CHECK_EN
   task automatic test_phase();
      do_reset();
      fout_rise = 4;
      run(256);
      tests++; if (locked_seen !== 0) begin fails++; $display("FAIL phase_inphase got=%0d exp=0", locked_seen); end
      fout_rise = 8;
      run(255);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL phase_early got=%0b exp=0", locked); end
      run(1);
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL phase_locked got=%0b exp=1", locked); end
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_ideal_lock();
      test_freq_error();
      test_holdover();
      test_loss();
      test_clear();
`ifdef DPLL_LOCK_PHASE_CHECK_EN
      test_phase();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
